vc_mux3_tdm_sched: RTL



---
 rtl/vc_mux3_tdm_sched_if.sv | 45 ++++
 rtl/vc_mux3_tdm_sched.sv | 118 +++++++++++
 2 files changed

// File: rtl/vc_mux3_tdm_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vc_mux3_tdm_sched_if                                            |
// | Purpose  : Bundle of request/handshake/select signals between the three    |
// |            security domains, the TDM scheduler and the shared output mux.  |
// | Signals  : req_val[2:0]  per-domain request valid (bit i = domain Li)      |
// |            req_rdy[2:0]  per-domain ready                                  |
// |            out_val       valid toward the mux-output consumer              |
// |            out_rdy       consumer ready                                    |
// |            sel[1:0]      mux select, 2'b11 = parked                        |
// |            cur_dom[1:0]  domain owning current / most recent slot          |
// |            slot_start    first cycle of every slot                         |
// | Modports : master = scheduler side, slave = requesters/consumer side       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface vc_mux3_tdm_sched_if;
   logic [2:0] req_val;
   logic [2:0] req_rdy;
   logic       out_val;
   logic       out_rdy;
   logic [1:0] sel;
   logic [1:0] cur_dom;
   logic       slot_start;

   modport master (
      input  req_val,
      input  out_rdy,
      output req_rdy,
      output out_val,
      output sel,
      output cur_dom,
      output slot_start
   );

   modport slave (
      output req_val,
      output out_rdy,
      input  req_rdy,
      input  out_val,
      input  sel,
      input  cur_dom,
      input  slot_start
   );
endinterface
`default_nettype wire

// File: rtl/vc_mux3_tdm_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vc_mux3_tdm_sched                                               |
// | Purpose  : Fixed time-division scheduler for a 3-domain output mux. Slots  |
// |            rotate domain 0 -> 1 -> 2 with a parked drain gap between them; |
// |            slot timing is independent of request activity.                |
// | Ports    : clk    clock                                                    |
// |            reset  synchronous, active-low reset                            |
// |            bus    vc_mux3_tdm_sched_if.master (req_val/req_rdy, out_val/   |
// |                   out_rdy, sel, cur_dom, slot_start)                       |
// | Params   : p_slot_len  cycles per domain slot (1..255)                     |
// |            p_drain_len dead cycles between slots (0..255, 0 = none)        |
// | Option   : VC_MUX3_SCHED_SKIP_IDLE_EN - work-conserving mode: a slot whose |
// |            owner is idle on its first cycle ends after that cycle.         |
// |            Not timing-channel free; non-secure builds only.                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module vc_mux3_tdm_sched #(
   parameter int unsigned p_slot_len  = 4,
   parameter int unsigned p_drain_len = 1
) (
   input  wire logic             clk,
   input  wire logic             reset,
   vc_mux3_tdm_sched_if.master   bus
);

   typedef enum logic [0:0] {
      SLOT  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam logic [7:0] c_slot_last  = 8'(p_slot_len - 1);
   localparam logic [7:0] c_drain_last = 8'(p_drain_len - 1);
   localparam bit         c_has_drain  = (p_drain_len != 0);

   state_t     r_state;
   logic [1:0] r_cur_dom;
   logic [7:0] r_cnt;

   state_t     w_state_nxt;
   logic [1:0] w_dom_nxt;
   logic [7:0] w_cnt_nxt;
   logic [1:0] w_next_dom;
   logic [2:0] w_dom_onehot;
   logic       w_slot_end;
   logic [1:0] w_sel;
   logic       w_out_val;
   logic [2:0] w_req_rdy;
   logic       w_slot_start;

   // Rotation never produces 3; the one-hot decode keeps every request bit
   // gated by the owning domain so no other domain's valid leaks out.
   assign w_next_dom   = (r_cur_dom == 2'd2) ? 2'd0 : r_cur_dom + 2'd1;
   assign w_dom_onehot = {r_cur_dom == 2'd2, r_cur_dom == 2'd1, r_cur_dom == 2'd0};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= SLOT;
         r_cur_dom <= 2'd0;
         r_cnt     <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_cur_dom <= w_dom_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_dom_nxt    = r_cur_dom;
      w_cnt_nxt    = r_cnt + 8'd1;
      w_sel        = 2'b11;
      w_out_val    = 1'b0;
      w_req_rdy    = 3'b000;
      w_slot_start = 1'b0;
      w_slot_end   = 1'b0;
      case (r_state)
         SLOT: begin
            w_sel        = r_cur_dom;
            w_out_val    = |(w_dom_onehot & bus.req_val);
            w_req_rdy    = w_dom_onehot & {3{bus.out_rdy}};
            w_slot_start = (r_cnt == 8'd0);
            w_slot_end   = (r_cnt == c_slot_last);
`ifdef VC_MUX3_SCHED_SKIP_IDLE_EN
            // Idle owner on the first slot cycle forfeits the rest of the slot.
            if ((r_cnt == 8'd0) && !(|(w_dom_onehot & bus.req_val)))
               w_slot_end = 1'b1;
`endif
            if (w_slot_end) begin
               w_cnt_nxt = 8'd0;
               if (c_has_drain)
                  w_state_nxt = DRAIN;
               else
                  w_dom_nxt = w_next_dom;
            end
         end
         DRAIN: begin
            // cur_dom keeps the previous owner until the next slot begins.
            if (r_cnt == c_drain_last) begin
               w_state_nxt = SLOT;
               w_dom_nxt   = w_next_dom;
               w_cnt_nxt   = 8'd0;
            end
         end
         default: begin
            w_state_nxt = SLOT;
         end
      endcase
   end

   assign bus.sel        = w_sel;
   assign bus.out_val    = w_out_val;
   assign bus.req_rdy    = w_req_rdy;
   assign bus.cur_dom    = r_cur_dom;
   assign bus.slot_start = w_slot_start;

endmodule
`default_nettype wire
